day2_dff_checker: RTL and testbench

- Synthesizable self-checking monitor for the day-2 DFF trio: the no-reset, sync-reset and async-reset flops.
- It watches the same d_i/reset stimulus the DUT sees, keeps its own reference copies of the three flops, and compares them with the DUT q outputs at every clock edge.
- It reports per-output mismatch flags and cycle/error counters.
- It sits beside the DFF DUT in the bench and replaces hand-inspection of waveforms.

---
 rtl/day2_dff_checker.sv | 128 ++++++++++++
 tb/tb_day2_dff_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/day2_dff_checker.sv
// day2_dff_checker: self-checking monitor for the no-reset, sync-reset and
// async-reset DFF trio. Keeps reference copies of the three flops, compares
// them with the DUT q outputs while in CHECK, and reports sticky mismatch
// flags plus saturating check/error counters.
// Optional feature macro: DFF_CHK_STOP_ON_ERR_EN (halt on first mismatch).
module day2_dff_checker #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             dut_reset_i,
    input  logic             d_i,
    input  logic             q_norst_i,
    input  logic             q_syncrst_i,
    input  logic             q_asyncrst_i,
    output logic [2:0]       mismatch_o,
    output logic             err_o,
    output logic [CNT_W-1:0] check_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef DFF_CHK_STOP_ON_ERR_EN
    typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, CHECK} state_t;
`endif

    state_t state;

    // reference flop models and their valid bits
    logic exp_n, exp_s, exp_a;
    logic v_n, v_s, v_a;

    logic       exp_async_c;
    logic [2:0] mm_c;
    logic [2:0] acc_c;
    logic       mm_any_c;
    logic       freeze_c;

    // expected values and mismatch vector for the current edge
    always_comb begin
        exp_async_c = dut_reset_i ? 1'b0 : exp_a;
        mm_c        = 3'b000;
        mm_c[0]     = v_n & (q_norst_i    != exp_n);
        mm_c[1]     = v_s & (q_syncrst_i  != exp_s);
        mm_c[2]     = v_a & (q_asyncrst_i != exp_async_c);
        mm_any_c    = |mm_c;
        acc_c       = mismatch_o | mm_c;
`ifdef DFF_CHK_STOP_ON_ERR_EN
        freeze_c    = (state == HALT);
`else
        freeze_c    = 1'b0;
`endif
    end

    // model update, FSM and registered results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            exp_n       <= 1'b0;
            exp_s       <= 1'b0;
            exp_a       <= 1'b0;
            v_n         <= 1'b0;
            v_s         <= 1'b0;
            v_a         <= 1'b0;
            mismatch_o  <= 3'b000;
            err_o       <= 1'b0;
            check_cnt_o <= '0;
            err_cnt_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            if (!freeze_c) begin
                exp_n <= d_i;
                exp_s <= dut_reset_i ? 1'b0 : d_i;
                exp_a <= dut_reset_i ? 1'b0 : d_i;
                v_n   <= 1'b1;
                v_s   <= 1'b1;
                v_a   <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (en_i) begin
                        state  <= CHECK;
                        busy_o <= 1'b1;
                    end
                end
                CHECK: begin
                    mismatch_o <= acc_c;
                    err_o      <= |acc_c;
                    if (check_cnt_o != CNT_MAX) begin
                        check_cnt_o <= check_cnt_o + CNT_W'(1);
                    end
                    if (mm_any_c && (err_cnt_o != CNT_MAX)) begin
                        err_cnt_o <= err_cnt_o + CNT_W'(1);
                    end
`ifdef DFF_CHK_STOP_ON_ERR_EN
                    if (mm_any_c) begin
                        state  <= HALT;
                        busy_o <= 1'b0;
                    end else if (!en_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
`else
                    if (!en_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
`endif
                end
`ifdef DFF_CHK_STOP_ON_ERR_EN
                HALT: begin
                    busy_o <= 1'b0;
                end
`endif
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_day2_dff_checker.sv
// Scoreboard bench for day2_dff_checker: a 16-bit and a 4-bit counter
// instance share stimulus; a behavioural model pushes the expected outputs
// per edge and a monitor pops and compares just after each rising edge.
module tb_day2_dff_checker;

    logic clk = 1'b0;
    logic reset, en, dut_reset, d, q_n, q_s, q_a;
    logic [2:0]  mm16, mm4;
    logic        err16, err4, busy16, busy4;
    logic [15:0] chk16, errc16;
    logic [3:0]  chk4, errc4;

    always #5 clk = ~clk;

    day2_dff_checker #(.CNT_W(16)) dut16 (
        .clk(clk), .reset(reset), .en_i(en), .dut_reset_i(dut_reset), .d_i(d),
        .q_norst_i(q_n), .q_syncrst_i(q_s), .q_asyncrst_i(q_a),
        .mismatch_o(mm16), .err_o(err16), .check_cnt_o(chk16),
        .err_cnt_o(errc16), .busy_o(busy16));

    day2_dff_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .en_i(en), .dut_reset_i(dut_reset), .d_i(d),
        .q_norst_i(q_n), .q_syncrst_i(q_s), .q_asyncrst_i(q_a),
        .mismatch_o(mm4), .err_o(err4), .check_cnt_o(chk4),
        .err_cnt_o(errc4), .busy_o(busy4));

    typedef struct {
        logic [2:0] mm;
        logic       err;
        int         chk;
        int         errc;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

`ifdef DFF_CHK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    // behavioural model: previous sampled inputs plus mode/accumulators
    bit       have_prev, prev_d, prev_r;
    bit       in_check, halted;
    bit [2:0] acc;
    int       n_chk, n_err;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        have_prev = 0; prev_d = 0; prev_r = 0;
        in_check = 0; halted = 0; acc = 3'b000; n_chk = 0; n_err = 0;
    endtask

    // called at a falling edge: drive one edge of stimulus and push its outcome
    task automatic step(input bit e, input bit dv, input bit rv, input bit [2:0] fault);
        bit en_, ea, es, ok;
        bit [2:0] mmv;
        exp_t x;
        en_ = prev_d;
        es  = prev_r ? 1'b0 : prev_d;
        ea  = rv ? 1'b0 : es;
        en = e; d = dv; dut_reset = rv;
        if (have_prev) begin
            q_n = en_ ^ fault[0];
            q_s = es  ^ fault[1];
            q_a = ea  ^ fault[2];
        end else begin
            q_n = 1'($urandom_range(1, 0));
            q_s = 1'($urandom_range(1, 0));
            q_a = 1'($urandom_range(1, 0));
        end
        ok  = in_check && !halted;
        mmv = (ok && have_prev) ? fault : 3'b000;
        if (ok) begin
            acc = acc | mmv;
            n_chk++;
            if (mmv != 0) n_err++;
        end
        if (!halted) begin
            prev_d = dv; prev_r = rv; have_prev = 1;
            if (ok && STOP && mmv != 0) halted = 1;
            else in_check = e;
        end
        x.mm = acc; x.err = |acc; x.chk = n_chk; x.errc = n_err;
        x.busy = in_check && !halted;
        sb.push_back(x);
        @(negedge clk);
    endtask

    // asynchronous checker reset applied mid-cycle, outputs checked at once
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_mm16", int'(mm16), 0);
        check("rst_err16", int'(err16), 0);
        check("rst_chk16", int'(chk16), 0);
        check("rst_errc16", int'(errc16), 0);
        check("rst_busy16", int'(busy16), 0);
        check("rst_chk4", int'(chk4), 0);
        sb.delete();
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // monitor: compare both instances against the queued expectation
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("mismatch16", int'(mm16), int'(x.mm));
                check("err16", int'(err16), int'(x.err));
                check("check_cnt16", int'(chk16), sat(x.chk, 16));
                check("err_cnt16", int'(errc16), sat(x.errc, 16));
                check("busy16", int'(busy16), int'(x.busy));
                check("mismatch4", int'(mm4), int'(x.mm));
                check("check_cnt4", int'(chk4), sat(x.chk, 4));
                check("err_cnt4", int'(errc4), sat(x.errc, 4));
                check("busy4", int'(busy4), int'(x.busy));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 0; dut_reset = 0; d = 0; q_n = 0; q_s = 0; q_a = 0;
        model_clear();
        @(negedge clk);
        do_reset();

        // clean run: d=0, one DUT reset cycle, then d=1
        step(1, 0, 0, 3'b000);
        step(1, 0, 1, 3'b000);
        for (int i = 0; i < 9; i++) step(1, 1, 0, 3'b000);
        check("clean_chk", int'(chk16), 10);
        check("clean_err", int'(errc16), 0);

        // async clear: DUT reset high with q_async still 1
        step(1, 1, 1, 3'b100);
        check("async_mm", int'(mm16), 4);
        check("async_errc", int'(errc16), 1);

        // sync reset fault: reset+d=1 at N, q_sync wrongly 1 at N+1
        do_reset();
        step(1, 1, 0, 3'b000);
        step(1, 1, 0, 3'b000);
        step(1, 1, 1, 3'b000);
        step(1, 0, 0, 3'b010);
        check("sync_mm", int'(mm16), 2);

        // startup: enable right after reset, then disable/re-enable
        do_reset();
        step(1, 1, 0, 3'b001);
        step(1, 0, 0, 3'b000);
        step(0, 0, 0, 3'b000);
        step(0, 1, 0, 3'b001);
        step(1, 1, 0, 3'b000);
        step(1, 0, 0, 3'b000);

        // saturation: mismatch on every edge
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 1'($urandom_range(1, 0)), 0, 3'b111);
        check("sat_chk4", int'(chk4), STOP ? 1 : 15);
        check("sat_err4", int'(errc4), STOP ? 1 : 15);

        // randomized run with occasional resets and rare faults
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit [2:0] f;
            f = 3'b000;
            if ($urandom_range(19, 0) == 0) f = 3'($urandom_range(7, 1));
            if ($urandom_range(399, 0) == 0) do_reset();
            else step(1'($urandom_range(7, 0) != 0), 1'($urandom_range(1, 0)),
                      1'($urandom_range(4, 0) == 0), f);
        end
        step(0, 0, 0, 3'b000);
        @(posedge clk);
        #2;
        check("queue_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
